// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the dual-requester ROM read arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic any
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            grant = ~last;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one asynchronous ROM between two requesters; IDLE -> READ -> RESP per read.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  winner;
    logic                  last;
    logic                  grant;
    logic                  any;

    rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (grant),
        .any   (any)
    );

    assign rom_addr = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            winner <= 1'b0;
            last   <= 1'b1;
            rdata  <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state  <= READ;
                        addr_q <= grant ? addr1 : addr0;
                        winner <= grant;
                        last   <= grant;
                        busy   <= 1'b1;
                    end
                end
                READ: begin
                    // ROM output settles during READ on the latched address
                    rdata <= rom_q;
                    ack0  <= ~winner;
                    ack1  <= winner;
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
